// File: rtl/irq_controller.sv
// Multi-channel external interrupt controller: synchronises request lines, latches pending events,
// masks and prioritises them, and runs the ExtIRQ/ExtIAck/ERet handshake with the processor core.
module irq_controller #(
   parameter int NCH = 4,
   parameter logic [NCH-1:0] EDGE_MASK = NCH'(4'b0011),
   parameter int SYNC_STG = 2,
   parameter int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           CLOCK_50,
   input  logic           reset,
   input  logic [NCH-1:0] irq_in,
   output logic [NCH-1:0] irq_ack,
   input  logic           mask_we,
   input  logic [NCH-1:0] mask_wdata,
   output logic [NCH-1:0] mask_q,
   output logic           ExtIRQ,
   input  logic           ExtIAck,
   input  logic           ERet,
   output logic [IDW-1:0] irq_id,
   output logic [NCH-1:0] pending_q
);

   typedef enum logic [1:0] {IDLE, REQ, ACK, SERVICE} state_t;

   state_t         state, state_nxt;
   logic [NCH-1:0] sync_ff [SYNC_STG];
   logic [NCH-1:0] s, s_d;
   logic [NCH-1:0] pending_nxt;
   logic [NCH-1:0] eligible;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] id_nxt;
   logic [NCH-1:0] ack_nxt;
   logic           irq_nxt;

   assign s        = sync_ff[SYNC_STG-1];
   assign eligible = pending_q & mask_q;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < SYNC_STG; k++) sync_ff[k] <= '0;
         s_d <= '0;
      end else begin
         sync_ff[0] <= irq_in;
         for (int k = 1; k < SYNC_STG; k++) sync_ff[k] <= sync_ff[k-1];
         s_d <= s;
      end
   end

   // Level channels are held pending while their own request is being acknowledged or serviced,
   // so a source that drops its line on irq_ack cannot race the handshake.
   always_comb begin
      pending_nxt = pending_q;
      for (int i = 0; i < NCH; i++) begin
         if (EDGE_MASK[i]) begin
            if (s[i] && !s_d[i])
               pending_nxt[i] = 1'b1;
            else if (state == ACK && irq_id == IDW'(i))
               pending_nxt[i] = 1'b0;
         end else begin
            if ((state == ACK || state == SERVICE) && irq_id == IDW'(i))
               pending_nxt[i] = pending_q[i] | s[i];
            else
               pending_nxt[i] = s[i];
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
         mask_q    <= '0;
      end else begin
         pending_q <= pending_nxt;
         if (mask_we) mask_q <= mask_wdata;
      end
   end

   // Scan from the top down so the lowest-numbered eligible channel ends up as the winner.
   always_comb begin
      winner = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (eligible[i]) winner = IDW'(i);
      end
   end

   always_comb begin
      state_nxt = state;
      irq_nxt   = ExtIRQ;
      id_nxt    = irq_id;
      ack_nxt   = '0;
      unique case (state)
         IDLE: begin
            irq_nxt = 1'b0;
            if (eligible != '0) begin
               state_nxt = REQ;
               id_nxt    = winner;
               irq_nxt   = 1'b1;
            end
         end
         REQ: begin
            if (ExtIAck) begin
               state_nxt       = ACK;
               irq_nxt         = 1'b0;
               ack_nxt[irq_id] = 1'b1;
            end else if (!eligible[irq_id]) begin
               state_nxt = IDLE;
               irq_nxt   = 1'b0;
            end
         end
         ACK: begin
            state_nxt = SERVICE;
            irq_nxt   = 1'b0;
         end
         SERVICE: begin
            irq_nxt = 1'b0;
            if (ERet) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            irq_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         ExtIRQ  <= 1'b0;
         irq_id  <= '0;
         irq_ack <= '0;
      end else begin
         state   <= state_nxt;
         ExtIRQ  <= irq_nxt;
         irq_id  <= id_nxt;
         irq_ack <= ack_nxt;
      end
   end

endmodule
